// File: rtl/tag_tx_phase_gen_if.sv
// AXI-Stream style phase-word channel from the tag transmit sequencer to the DDS.
interface tag_tx_phase_gen_if #(
  parameter int unsigned PHASE_WIDTH = 24
) ();
  logic [PHASE_WIDTH-1:0] m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;
  logic                   m_tuser;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    output m_tuser,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    input  m_tuser,
    output m_tready
  );
endinterface

// File: rtl/tag_tx_phase_gen.sv
// Tag-side transmit sequencer: stepped-frequency phase stream, framed as NSYMB symbols of
// NSIG samples, with start/stop control, frame counting, inter-frame gap and backpressure.
module tag_tx_phase_gen #(
  parameter int unsigned PHASE_WIDTH  = 24,
  parameter int unsigned NSYMB_WIDTH  = 16,
  parameter int unsigned FRAME_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH    = 16,
  parameter int unsigned NSYMB        = 64,
  parameter int unsigned NSIG         = 327680,
  parameter int unsigned DPH_INC      = 131072,
  parameter int unsigned START_PH_INC = 0,
  parameter int unsigned START_PH     = 0,
  parameter int unsigned GAP_LEN      = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [FRAME_WIDTH-1:0] nframes,
  tag_tx_phase_gen_if.master     m,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_WIDTH-1:0] frame_cnt,
  output logic [NSYMB_WIDTH-1:0] symb_idx,
  output logic [PHASE_WIDTH-1:0] samp_idx
);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  localparam logic [PHASE_WIDTH-1:0] NSigW     = PHASE_WIDTH'(NSIG);
  localparam logic [NSYMB_WIDTH-1:0] NSymbW    = NSYMB_WIDTH'(NSYMB);
  localparam logic [PHASE_WIDTH-1:0] StartPh   = PHASE_WIDTH'(START_PH);
  localparam logic [PHASE_WIDTH-1:0] StartInc  = PHASE_WIDTH'(START_PH_INC);
  localparam logic [PHASE_WIDTH-1:0] DphInc    = PHASE_WIDTH'(DPH_INC);
  localparam logic [GAP_WIDTH-1:0]   GapLast   = (GAP_LEN == 0) ? '0 : GAP_WIDTH'(GAP_LEN - 1);

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic [PHASE_WIDTH-1:0] samp_q, samp_d;
  logic [NSYMB_WIDTH-1:0] symb_q, symb_d;
  logic [FRAME_WIDTH-1:0] nframes_q, nframes_d;
  logic [FRAME_WIDTH-1:0] run_frames_q, run_frames_d;
  logic [FRAME_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   stop_q, stop_d;
  logic                   frame_done_q, frame_done_d;
  logic                   end_run;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    inc_d        = inc_q;
    samp_d       = samp_q;
    symb_d       = symb_q;
    nframes_d    = nframes_q;
    run_frames_d = run_frames_q;
    frame_cnt_d  = frame_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    stop_d       = stop_q;
    frame_done_d = 1'b0;
    end_run      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // stop is discarded here, including when it coincides with start
        if (start) begin
          state_d      = StRun;
          nframes_d    = nframes;
          phase_d      = StartPh;
          inc_d        = StartInc;
          samp_d       = PHASE_WIDTH'(1);
          symb_d       = NSYMB_WIDTH'(1);
          run_frames_d = '0;
          stop_d       = 1'b0;
        end
      end

      StRun: begin
        if (stop) stop_d = 1'b1;
        if (m.m_tready) begin
          if (samp_q != NSigW) begin
            phase_d = phase_q + inc_q;
            samp_d  = samp_q + PHASE_WIDTH'(1);
          end else begin
            samp_d  = PHASE_WIDTH'(1);
            phase_d = StartPh;
            if (symb_q != NSymbW) begin
              symb_d = symb_q + NSYMB_WIDTH'(1);
              inc_d  = inc_q + DphInc;
            end else begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + FRAME_WIDTH'(1);
              run_frames_d = run_frames_q + FRAME_WIDTH'(1);
              symb_d       = NSYMB_WIDTH'(1);
              inc_d        = StartInc;
              end_run      = stop_q || stop ||
                             ((nframes_q != '0) && (run_frames_d == nframes_q));
              if (end_run) begin
                state_d = StIdle;
                stop_d  = 1'b0;
              end else if (GAP_LEN != 0) begin
                state_d   = StGap;
                gap_cnt_d = '0;
              end
            end
          end
        end
      end

      StGap: begin
        if (stop_q || stop) begin
          state_d = StIdle;
          stop_d  = 1'b0;
        end else if (gap_cnt_q == GapLast) begin
          state_d = StRun;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= StartPh;
      inc_q        <= StartInc;
      samp_q       <= PHASE_WIDTH'(1);
      symb_q       <= NSYMB_WIDTH'(1);
      nframes_q    <= '0;
      run_frames_q <= '0;
      frame_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      stop_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      inc_q        <= inc_d;
      samp_q       <= samp_d;
      symb_q       <= symb_d;
      nframes_q    <= nframes_d;
      run_frames_q <= run_frames_d;
      frame_cnt_q  <= frame_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      stop_q       <= stop_d;
      frame_done_q <= frame_done_d;
    end
  end

  // All stream outputs decode registered state only; tready never reaches tvalid.
  assign m.m_tvalid = (state_q == StRun);
  assign m.m_tdata  = phase_q;
  assign m.m_tlast  = (state_q == StRun) && (samp_q == NSigW);
  assign m.m_tuser  = (state_q == StRun) && (samp_q == PHASE_WIDTH'(1)) &&
                      (symb_q == NSYMB_WIDTH'(1));

  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign symb_idx   = symb_q;
  assign samp_idx   = samp_q;

endmodule
